adc_decimator: RTL
==================

Name: adc_decimator

Overview:
- Upstream neighbour of the sampler stage: turns the continuous ZMOD ADC stream (reference + error channels) into a decimated sample stream with a one-cycle sample strobe.
- Strobe and data feed the sampler's sample-enable and data inputs.
- Decimation ratio N = 2^k; k is programmed by the IAGC controller during SET_DEC.
- Optional compile-time boxcar averaging over each N-sample window.

Parameters:
- ZMOD_DATA_SIZE, 14, width of each ADC channel (signed two's complement).
- DEC_LOG2_SIZE, 4, width of the decimation exponent input.
- MAX_DEC_LOG2, 8, largest supported exponent k; larger requests clamp to this value.

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_reference  in  ZMOD_DATA_SIZE  ADC reference channel sample.
- i_error  in  ZMOD_DATA_SIZE  ADC error channel sample.
- i_valid  in  1  ADC data valid; both channels sampled together.
- i_enable  in  1  decimation enabled (high while IAGC is in SAMPLE).
- i_dec_log2  in  DEC_LOG2_SIZE  requested exponent k.
- i_dec_load  in  1  one-cycle pulse: latch i_dec_log2.
- o_reference  out  ZMOD_DATA_SIZE  decimated reference sample.
- o_error  out  ZMOD_DATA_SIZE  decimated error sample.
- o_sample  out  1  one-cycle strobe; o_reference/o_error valid on this cycle.
- o_dec_log2  out  DEC_LOG2_SIZE  currently active exponent (after clamp).

Behaviour:
- Reset (async, i_reset=1): state IDLE, o_dec_log2=0 (N=1), window counter=0, accumulators=0, o_reference=0, o_error=0, o_sample=0.
- Exponent register:
  - On i_dec_load, dec_log2 <= min(i_dec_log2, MAX_DEC_LOG2).
  - The window counter and accumulators clear on the same edge; any partial window is discarded.
  - i_dec_load has priority over a window-completing i_valid in the same cycle: no strobe is produced.
- Window counter width: MAX_DEC_LOG2 bits (DEC_LOG2_SIZE+1 minimum if MAX_DEC_LOG2=0 is ever used).
  - Terminal count is (1<<dec_log2)-1.
- FSM:
  - IDLE: counter and accumulators held at 0, o_sample=0. Goes to RUN when i_enable=1. The first i_valid is counted on the cycle after entry.
  - RUN: each i_valid=1 cycle increments the counter. On a valid that hits the terminal count, the counter wraps to 0 and o_sample=1 on the next cycle (latency 1 clock from the completing i_valid). Goes to IDLE when i_enable=0; the partial window is discarded and no strobe is produced.
- Without averaging: outputs register the channel data of the window's LAST valid sample (pure decimation).
  - N=1 gives a strobe for every valid, 1-cycle delayed.
- o_reference/o_error hold their last value between strobes.
- o_sample is never asserted in consecutive cycles unless N=1 and i_valid is continuous.
- i_valid=0 cycles are ignored and do not advance the counter.
- o_dec_log2 reflects the register immediately after the load edge.

Optional Feature:
- Macro: ADC_DECIMATOR_AVERAGE_EN.
- Defined:
  - Two signed accumulators of width ZMOD_DATA_SIZE+MAX_DEC_LOG2 sum every valid sample in the window, including the completing one.
  - Output = accumulator >>> dec_log2 (arithmetic shift, truncation toward -inf), taking the low ZMOD_DATA_SIZE bits.
  - Accumulators restart from the completing sample's successor; no sample is lost or double-counted.
- Not defined: no accumulators are synthesised; last-sample decimation as above.
- Port list is identical in both builds.

Decomposition:
- Shared package iagc_pkg:
  - IAGC status codes (RESET..HALT, 4-bit).
  - ZMOD_DATA_SIZE.
  - MAX_DEC_LOG2.
  - Decimator FSM state constants (IDLE=0, RUN=1).
- One sub-module, decim_accumulator: a per-channel signed accumulate/clear/shift unit. It is instantiated twice (reference, error) and only under ADC_DECIMATOR_AVERAGE_EN.

Test Plan:
- Reset mid-run: assert i_reset asynchronously between clock edges while in RUN with counter=3 -> all outputs 0 immediately, o_dec_log2=0; after release with i_enable=1, first valid gives a strobe (N=1).
- Decimate by 4: load k=2, enable, drive i_valid continuous with reference=0,1,2,…,11 -> o_sample on cycles after samples 3, 7, 11; o_reference=3, 7, 11 (with AVERAGE_EN: 1, 5, 9).
- Gapped valid: k=1, i_valid pattern 1,0,0,1,1,0,1 with error=-5,x,x,-3,7,x,9 -> strobes after the 2nd and 4th valid; o_error=-3 then 9 (AVERAGE_EN: -4, then 8).
- Clamp and load priority: i_dec_log2=15 -> o_dec_log2=8. Pulse i_dec_load (k=0) in the same cycle as a window-completing valid -> no strobe that cycle; next valid strobes.
- Disable mid-window: k=3, 5 valids, drop i_enable, re-enable -> no strobe; next strobe only after 8 fresh valids.
- Negative averaging (AVERAGE_EN): k=1, reference=-1,-2 -> o_reference=-2 (0x3FFE, floor of -1.5).

Source files
------------

// File: rtl/iagc_pkg.sv
`default_nettype none
// =============================================================================
// iagc_pkg: shared IAGC status codes, ADC widths and decimator state encoding.
// Revision: 1.0
// =============================================================================
package iagc_pkg;

   localparam int ZMOD_DATA_SIZE = 14;
   localparam int MAX_DEC_LOG2   = 8;

   typedef enum logic [3:0] {
      IAGC_RESET   = 4'd0,
      IAGC_INIT    = 4'd1,
      IAGC_SET_DEC = 4'd2,
      IAGC_SAMPLE  = 4'd3,
      IAGC_ADJUST  = 4'd4,
      IAGC_HALT    = 4'd5
   } iagc_status_t;

   typedef enum logic {
      DEC_IDLE = 1'b0,
      DEC_RUN  = 1'b1
   } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/decim_accumulator.sv
`default_nettype none
// =============================================================================
// decim_accumulator: per-channel signed window sum with arithmetic-shift average.
// Only built when ADC_DECIMATOR_AVERAGE_EN is defined. Revision: 1.0
// =============================================================================
`ifdef ADC_DECIMATOR_AVERAGE_EN
module decim_accumulator #(
   parameter int DATA_W  = 14,
   parameter int ACC_W   = 22,
   parameter int SHIFT_W = 4
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_clear,
   input  logic                     i_add,
   input  logic                     i_wrap,
   input  logic signed [DATA_W-1:0] i_data,
   input  logic [SHIFT_W-1:0]       i_shift,
   output logic [DATA_W-1:0]        o_result
);
   import iagc_pkg::*;

   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_data_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_shifted;
   logic                    w_unused_hi;

   assign w_data_ext  = $signed({{(ACC_W-DATA_W){i_data[DATA_W-1]}}, i_data});
   // The result includes the sample currently being accepted.
   assign w_sum       = r_acc + w_data_ext;
   assign w_shifted   = w_sum >>> i_shift;
   assign o_result    = w_shifted[DATA_W-1:0];
   assign w_unused_hi = ^w_shifted[ACC_W-1:DATA_W];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_acc <= '0;
      end else if (i_clear || (i_add && i_wrap)) begin
         r_acc <= '0;
      end else if (i_add) begin
         r_acc <= w_sum;
      end
   end

endmodule
`endif
`default_nettype wire

// File: rtl/adc_decimator.sv
`default_nettype none
// =============================================================================
// adc_decimator: decimates the ZMOD reference/error stream by 2^k with a sample
// strobe; ADC_DECIMATOR_AVERAGE_EN adds boxcar averaging. Revision: 1.0
// =============================================================================
module adc_decimator #(
   parameter int ZMOD_DATA_SIZE = iagc_pkg::ZMOD_DATA_SIZE,
   parameter int DEC_LOG2_SIZE  = 4,
   parameter int MAX_DEC_LOG2   = iagc_pkg::MAX_DEC_LOG2
) (
   input  logic                             i_clock,
   input  logic                             i_reset,
   input  logic signed [ZMOD_DATA_SIZE-1:0] i_reference,
   input  logic signed [ZMOD_DATA_SIZE-1:0] i_error,
   input  logic                             i_valid,
   input  logic                             i_enable,
   input  logic [DEC_LOG2_SIZE-1:0]         i_dec_log2,
   input  logic                             i_dec_load,
   output logic signed [ZMOD_DATA_SIZE-1:0] o_reference,
   output logic signed [ZMOD_DATA_SIZE-1:0] o_error,
   output logic                             o_sample,
   output logic [DEC_LOG2_SIZE-1:0]         o_dec_log2
);
   import iagc_pkg::*;

   localparam int CNT_W = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : DEC_LOG2_SIZE + 1;
   localparam logic [31:0] C_MAX_K_FULL = MAX_DEC_LOG2;
   localparam logic [DEC_LOG2_SIZE-1:0] C_MAX_K = C_MAX_K_FULL[DEC_LOG2_SIZE-1:0];

   dec_state_t                  r_state;
   dec_state_t                  w_state_next;
   logic [DEC_LOG2_SIZE-1:0]    r_dec_log2;
   logic [CNT_W-1:0]            r_count;
   logic [CNT_W-1:0]            w_term;
   logic                        w_accept;
   logic                        w_complete;
   logic                        w_clear;
   logic [ZMOD_DATA_SIZE-1:0]   w_ref_sample;
   logic [ZMOD_DATA_SIZE-1:0]   w_err_sample;
   logic signed [ZMOD_DATA_SIZE-1:0] r_reference;
   logic signed [ZMOD_DATA_SIZE-1:0] r_error;
   logic                        r_sample;

   assign w_term     = ~({CNT_W{1'b1}} << r_dec_log2);
   assign w_complete = w_accept && (r_count == w_term);
   // A load, an idle state or a dropped enable all discard the partial window.
   assign w_clear    = i_dec_load || !((r_state == DEC_RUN) && i_enable);

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         DEC_IDLE: begin
            if (i_enable) begin
               w_state_next = DEC_RUN;
            end
         end
         DEC_RUN: begin
            if (!i_enable) begin
               w_state_next = DEC_IDLE;
            end else if (i_valid && !i_dec_load) begin
               w_accept = 1'b1;
            end
         end
         default: w_state_next = DEC_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= DEC_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_dec_log2 <= '0;
      end else if (i_dec_load) begin
         r_dec_log2 <= (i_dec_log2 > C_MAX_K) ? C_MAX_K : i_dec_log2;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (w_clear || w_complete) begin
         r_count <= '0;
      end else if (w_accept) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

`ifdef ADC_DECIMATOR_AVERAGE_EN
   decim_accumulator #(
      .DATA_W  (ZMOD_DATA_SIZE),
      .ACC_W   (ZMOD_DATA_SIZE + MAX_DEC_LOG2),
      .SHIFT_W (DEC_LOG2_SIZE)
   ) u_acc_reference (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (w_clear),
      .i_add    (w_accept),
      .i_wrap   (w_complete),
      .i_data   (i_reference),
      .i_shift  (r_dec_log2),
      .o_result (w_ref_sample)
   );

   decim_accumulator #(
      .DATA_W  (ZMOD_DATA_SIZE),
      .ACC_W   (ZMOD_DATA_SIZE + MAX_DEC_LOG2),
      .SHIFT_W (DEC_LOG2_SIZE)
   ) u_acc_error (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (w_clear),
      .i_add    (w_accept),
      .i_wrap   (w_complete),
      .i_data   (i_error),
      .i_shift  (r_dec_log2),
      .o_result (w_err_sample)
   );
`else
   assign w_ref_sample = i_reference;
   assign w_err_sample = i_error;
`endif

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_sample    <= 1'b0;
         r_reference <= '0;
         r_error     <= '0;
      end else begin
         r_sample <= w_complete;
         if (w_complete) begin
            r_reference <= $signed(w_ref_sample);
            r_error     <= $signed(w_err_sample);
         end
      end
   end

   assign o_sample    = r_sample;
   assign o_reference = r_reference;
   assign o_error     = r_error;
   assign o_dec_log2  = r_dec_log2;

endmodule
`default_nettype wire
